clk_wiz_lock_supervisor: RTL and testbench

Control-side companion to the clocking-wizard network: drives the wizard's `reset` and `power_down` inputs and consumes its `locked` and `input_clk_stopped` status. It sequences the initial reset, waits for lock with a timeout, and qualifies lock stability before releasing `clk_ok` to downstream logic. It also re-arms the wizard on lock loss and latches a fault after repeated failures. It runs on the free-running input clock `clk_in1`, upstream of the wizard instance.

---
 rtl/clk_wiz_pkg.sv | 26 ++
 rtl/sync_2ff.sv | 25 ++
 rtl/clk_wiz_lock_supervisor.sv | 128 ++++++++++++
 tb/tb_clk_wiz_lock_supervisor.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_wiz_pkg.sv
// Shared types and defaults for the clocking-wizard lock supervisor.
package clk_wiz_pkg;

  typedef enum logic [2:0] {
    ST_RST_HOLD,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_RUN,
    ST_PWR_DN,
    ST_FAULT
  } sup_state_t;

  localparam int DEF_RST_CYCLES    = 16;
  localparam int DEF_LOCK_TIMEOUT  = 65536;
  localparam int DEF_STABLE_CYCLES = 1024;
  localparam int DEF_MAX_RETRIES   = 3;
  localparam int RELOCK_W          = 8;

  // Largest of three phase lengths; sizes the shared phase counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for slow asynchronous status levels.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Two register stages; the first may go metastable, the second settles it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      // NOTE: non-blocking so both stages sample pre-edge values; blocking would collapse them into one flop.
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/clk_wiz_lock_supervisor.sv
// Sequences wizard reset, waits for and qualifies lock, re-arms on lock
// loss, powers down on request and latches a fault after repeated failures.
module clk_wiz_lock_supervisor
  import clk_wiz_pkg::*;
#(
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int MAX_RETRIES   = DEF_MAX_RETRIES
) (
  input  logic                clk_in1,
  input  logic                reset,
  input  logic                locked,
  input  logic                input_clk_stopped,
  input  logic                pd_req,
  output logic                mmcm_reset,
  output logic                mmcm_power_down,
  output logic                clk_ok,
  output logic                fault,
  output logic [1:0]          retry_cnt,
  output logic [RELOCK_W-1:0] relock_cnt
);

  localparam int CNT_W = $clog2(max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES));
  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [1:0]       RETRY_MAX   = 2'(MAX_RETRIES);

  sup_state_t          state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [1:0]          retry_n;
  logic [RELOCK_W-1:0] relock_n;
  logic                fail;
  logic                mmcm_reset_n, mmcm_power_down_n, clk_ok_n, fault_n;
  logic [1:0]          sync_q;
  logic                lk_s, stp_s;

  sync_2ff #(.WIDTH(2)) u_sync (
    .clk (clk_in1),
    .rst (reset),
    .d   ({input_clk_stopped, locked}),
    .q   (sync_q)
  );

  assign lk_s  = sync_q[0];
  assign stp_s = sync_q[1];

  // Next-state, shared counter, retry/relock bookkeeping and next outputs.
  always_comb begin
    // NOTE: every target gets a default first so no path can leave one unassigned and infer a latch.
    state_n  = state;
    cnt_n    = cnt + CNT_W'(1);
    retry_n  = retry_cnt;
    relock_n = relock_cnt;
    fail     = 1'b0;

    if (pd_req && state != ST_FAULT) begin
      state_n = ST_PWR_DN;
    end else begin
      case (state)
        ST_RST_HOLD:  if (cnt == RST_LAST) state_n = ST_WAIT_LOCK;
        ST_WAIT_LOCK: begin
          if (lk_s)                   state_n = ST_STABLE;
          else if (cnt == LOCK_LAST)  fail = 1'b1;
        end
        ST_STABLE: begin
          if (!lk_s || stp_s) begin
            fail = 1'b1;
          end else if (cnt == STABLE_LAST) begin
            state_n = ST_RUN;
            retry_n = '0;
          end
        end
        ST_RUN: begin
          if (!lk_s || stp_s) begin
            if (relock_cnt != '1) relock_n = relock_cnt + RELOCK_W'(1);
            state_n = ST_RST_HOLD;
          end
        end
        ST_PWR_DN:    state_n = ST_RST_HOLD;
        ST_FAULT:     state_n = ST_FAULT;
        default:      state_n = ST_RST_HOLD;
      endcase
    end

    if (fail) begin
      if (retry_cnt == RETRY_MAX) begin
        state_n = ST_FAULT;
      end else begin
        retry_n = retry_cnt + 2'd1;
        state_n = ST_RST_HOLD;
      end
    end

    if (state_n != state) cnt_n = '0;

    mmcm_reset_n      = (state_n == ST_RST_HOLD) || (state_n == ST_PWR_DN) ||
                        (state_n == ST_FAULT);
    mmcm_power_down_n = (state_n == ST_PWR_DN) || (state_n == ST_FAULT);
    clk_ok_n          = (state_n == ST_RUN);
    fault_n           = (state_n == ST_FAULT);
  end

  // State, counter and registered outputs all move on the same edge.
  always_ff @(posedge clk_in1 or posedge reset) begin
    if (reset) begin
      state           <= ST_RST_HOLD;
      cnt             <= '0;
      retry_cnt       <= '0;
      relock_cnt      <= '0;
      mmcm_reset      <= 1'b1;
      mmcm_power_down <= 1'b0;
      clk_ok          <= 1'b0;
      fault           <= 1'b0;
    end else begin
      state           <= state_n;
      cnt             <= cnt_n;
      retry_cnt       <= retry_n;
      relock_cnt      <= relock_n;
      mmcm_reset      <= mmcm_reset_n;
      mmcm_power_down <= mmcm_power_down_n;
      clk_ok          <= clk_ok_n;
      fault           <= fault_n;
    end
  end

endmodule

// File: tb/tb_clk_wiz_lock_supervisor.sv
// Scoreboard bench: a driver steps a phase-level reference model each cycle and
// queues the expected outputs; a monitor pops and compares after every edge.
module tb_clk_wiz_lock_supervisor;

  localparam int R = 4;
  localparam int T = 32;
  localparam int S = 8;
  localparam int M = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       locked = 1'b0;
  logic       input_clk_stopped = 1'b0;
  logic       pd_req = 1'b0;
  logic       mmcm_reset, mmcm_power_down, clk_ok, fault;
  logic [1:0] retry_cnt;
  logic [7:0] relock_cnt;

  always #5 clk = ~clk;

  clk_wiz_lock_supervisor #(
    .RST_CYCLES(R), .LOCK_TIMEOUT(T), .STABLE_CYCLES(S), .MAX_RETRIES(M)
  ) dut (
    .clk_in1           (clk),
    .reset             (reset),
    .locked            (locked),
    .input_clk_stopped (input_clk_stopped),
    .pd_req            (pd_req),
    .mmcm_reset        (mmcm_reset),
    .mmcm_power_down   (mmcm_power_down),
    .clk_ok            (clk_ok),
    .fault             (fault),
    .retry_cnt         (retry_cnt),
    .relock_cnt        (relock_cnt)
  );

  typedef struct packed {
    logic       mrst;
    logic       pdn;
    logic       ok;
    logic       flt;
    logic [1:0] retry;
    logic [7:0] relock;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: phase name, cycles spent in phase, and the two-deep
  // delay lines that stand in for the status synchronizers.
  string m_phase = "hold";
  int    m_t = 0, m_retry = 0, m_relock = 0;
  bit    m_lk1 = 0, m_lks = 0, m_st1 = 0, m_sts = 0;
  int    wiz_cnt = 0;

  function automatic exp_t model_out();
    exp_t e;
    e.mrst   = (m_phase == "hold") || (m_phase == "pd") || (m_phase == "fault");
    e.pdn    = (m_phase == "pd") || (m_phase == "fault");
    e.ok     = (m_phase == "run");
    e.flt    = (m_phase == "fault");
    e.retry  = 2'(m_retry);
    e.relock = 8'(m_relock);
    return e;
  endfunction

  task automatic model_reset();
    m_phase = "hold"; m_t = 0; m_retry = 0; m_relock = 0;
    m_lk1 = 0; m_lks = 0; m_st1 = 0; m_sts = 0;
  endtask

  task automatic goto_phase(input string ph);
    m_phase = ph;
    m_t = 0;
  endtask

  task automatic attempt_failed();
    if (m_retry == M) goto_phase("fault");
    else begin
      m_retry++;
      goto_phase("hold");
    end
  endtask

  // One rising edge of the model, using the inputs driven before it.
  task automatic model_edge(input bit lk, input bit stp, input bit pd, input bit rst);
    bit seen_lk, seen_stp;
    if (rst) begin
      model_reset();
      return;
    end
    seen_lk  = m_lks;
    seen_stp = m_sts;
    m_lks = m_lk1; m_lk1 = lk;
    m_sts = m_st1; m_st1 = stp;
    if (pd && m_phase != "fault") begin
      if (m_phase != "pd") goto_phase("pd");
    end else if (m_phase == "hold") begin
      if (m_t == R - 1) goto_phase("wait"); else m_t++;
    end else if (m_phase == "wait") begin
      if (seen_lk) goto_phase("stable");
      else if (m_t == T - 1) attempt_failed();
      else m_t++;
    end else if (m_phase == "stable") begin
      if (!seen_lk || seen_stp) attempt_failed();
      else if (m_t == S - 1) begin
        m_retry = 0;
        goto_phase("run");
      end else m_t++;
    end else if (m_phase == "run") begin
      if (!seen_lk || seen_stp) begin
        if (m_relock < 255) m_relock++;
        goto_phase("hold");
      end
    end else if (m_phase == "pd") begin
      goto_phase("hold");
    end
  endtask

  task automatic check_vec(input string name, input exp_t got, input exp_t want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s @%0t: got mrst=%0b pdn=%0b ok=%0b flt=%0b retry=%0d relock=%0d, expected mrst=%0b pdn=%0b ok=%0b flt=%0b retry=%0d relock=%0d",
               name, $time, got.mrst, got.pdn, got.ok, got.flt, got.retry, got.relock,
               want.mrst, want.pdn, want.ok, want.flt, want.retry, want.relock);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, got, want);
    end
  endtask

  function automatic exp_t dut_out();
    exp_t g;
    g = {mmcm_reset, mmcm_power_down, clk_ok, fault, retry_cnt, relock_cnt};
    return g;
  endfunction

  // Monitor: every edge produces an output word; compare it to the oldest expectation.
  initial begin
    exp_t want;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        check_vec("outputs", dut_out(), want);
      end
    end
  end

  // Drive inputs at the falling edge and queue the response for the next rising edge.
  task automatic cycle(input bit lk, input bit stp, input bit pd, input bit rst);
    @(negedge clk);
    locked = lk; input_clk_stopped = stp; pd_req = pd; reset = rst;
    model_edge(lk, stp, pd, rst);
    exp_q.push_back(model_out());
  endtask

  // Wizard stand-in: lock is lost while its reset is held and returns
  // 'delay' cycles after reset is released; force_low injects a dropout.
  task automatic wcycle(input int delay, input bit force_low, input bit stp, input bit pd);
    exp_t cur;
    bit   lk;
    cur = model_out();
    lk  = !cur.mrst && (wiz_cnt >= delay) && !force_low;
    if (cur.mrst) wiz_cnt = 0;
    else if (wiz_cnt < 1000000) wiz_cnt++;
    cycle(lk, stp, pd, 1'b0);
  endtask

  task automatic run_until(input string ph, input int delay, input int budget, input string name);
    int n;
    n = 0;
    while (m_phase != ph && n < budget) begin
      wcycle(delay, 0, 0, 0);
      n++;
    end
    if (m_phase != ph) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: phase %s not reached within %0d cycles", name, ph, budget);
    end
  endtask

  task automatic hold_reset(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 1);
    wiz_cnt = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    int   rst_hi, ok_edge, d, len, pd_left;
    exp_t rv;

    // 1: release with the wizard locking as soon as its reset drops.
    hold_reset(3);
    rst_hi = 0;
    ok_edge = -1;
    for (int k = 1; k <= 30; k++) begin
      wcycle(0, 0, 0, 0);
      if (k <= 10 && mmcm_reset) rst_hi++;
      if (ok_edge < 0 && clk_ok) ok_edge = k - 1;
    end
    check_int("s1_reset_pulse_len", rst_hi, R);
    check_int("s1_clk_ok_edge", ok_edge, R + 2 + 1 + S);

    // 2: lock never arrives; four timeouts latch the fault.
    hold_reset(2);
    for (int i = 0; i < 4 * (R + T) + 20; i++) wcycle(1000000, 0, 0, 0);
    check_int("s2_fault", fault, 1);
    check_int("s2_power_down", mmcm_power_down, 1);
    for (int i = 0; i < 40; i++) wcycle(0, 0, 0, 0);
    check_int("s2_fault_sticky", fault, 1);
    check_int("s2_retry_final", retry_cnt, M);

    // 3: five-cycle lock dropout in RUN.
    hold_reset(2);
    d = $urandom_range(0, 5);
    run_until("run", d, 200, "s3_first_run");
    for (int i = 0; i < 3; i++) wcycle(d, 0, 0, 0);
    for (int i = 0; i < 5; i++) wcycle(d, 1, 0, 0);
    check_int("s3_clk_ok_low", clk_ok, 0);
    check_int("s3_relock_cnt", relock_cnt, 1);
    run_until("run", d, 200, "s3_requalify");
    wcycle(d, 0, 0, 0);

    // 4: two-cycle dropout during STABLE.
    wcycle(d, 1, 0, 0);
    run_until("stable", d, 200, "s4_reach_stable");
    for (int i = 0; i < int'($urandom_range(0, 4)); i++) wcycle(d, 0, 0, 0);
    wcycle(d, 1, 0, 0);
    wcycle(d, 1, 0, 0);
    for (int i = 0; i < 5; i++) wcycle(d, 0, 0, 0);
    check_int("s4_retry_cnt", retry_cnt, 1);
    run_until("run", d, 200, "s4_requalify");
    wcycle(d, 0, 0, 0);
    check_int("s4_retry_cleared", retry_cnt, 0);

    // 5: power-down request during RUN.
    len = $urandom_range(2, 6);
    for (int i = 0; i < len; i++) begin
      wcycle(d, 0, 0, 1);
      if (i == 1) begin
        check_int("s5_power_down", mmcm_power_down, 1);
        check_int("s5_clk_ok_low", clk_ok, 0);
      end
    end
    run_until("run", d, 200, "s5_rerelease");

    // 6: 300 lock losses saturate the relock counter.
    for (int i = 0; i < 300; i++) begin
      d = $urandom_range(0, 3);
      run_until("run", d, 200, "s6_reach_run");
      for (int j = 0; j < int'($urandom_range(0, 3)); j++) wcycle(d, 0, 0, 0);
      if ($urandom_range(0, 1) == 1) begin
        for (int j = 0; j < int'($urandom_range(1, 3)); j++) wcycle(d, 1, 0, 0);
      end else begin
        for (int j = 0; j < int'($urandom_range(1, 2)); j++) wcycle(d, 0, 1, 0);
      end
      run_until("hold", d, 20, "s6_loss_seen");
    end
    for (int i = 0; i < 6; i++) wcycle(d, 0, 0, 0);
    check_int("s6_relock_saturated", relock_cnt, 255);

    // Asynchronous reset between edges while in STABLE.
    run_until("stable", d, 200, "s6_reach_stable");
    wcycle(d, 0, 0, 0);
    wcycle(d, 0, 0, 0);
    @(posedge clk);
    #3;
    reset = 1'b1;
    model_reset();
    wiz_cnt = 0;
    #1;
    rv = model_out();
    check_vec("async_reset", dut_out(), rv);
    hold_reset(2);

    // Randomized soak: dropouts, stopped-clock pulses, power-down bursts, resets.
    pd_left = 0;
    d = $urandom_range(0, 4);
    for (int i = 0; i < 1500; i++) begin
      if (i % 100 == 0) d = $urandom_range(0, 4);
      if (pd_left == 0 && $urandom_range(0, 199) == 0) pd_left = $urandom_range(1, 8);
      if ($urandom_range(0, 499) == 0) begin
        hold_reset(2);
      end else begin
        wcycle(d, $urandom_range(0, 29) == 0, $urandom_range(0, 49) == 0, pd_left > 0);
      end
      if (pd_left > 0) pd_left--;
    end
    wcycle(d, 0, 0, 0);
    @(posedge clk);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
